// File: rtl/btn_debounce_ctrl.sv
// btn_debounce_ctrl: multi-channel push-button debouncer with a press strobe.
//
// Each raw button level is synchronized through two flops and then has to
// differ from the accepted level for DEBOUNCE_CYCLES consecutive clocks
// before it is accepted. A rising accepted level issues a one-cycle strobe.
// Bit 0 feeds the ALU A-load, bit 1 the B-load and bit 2 the Op-load.
//
// Optional feature: define BTN_AUTOREPEAT_EN to re-issue the strobe every
// REPEAT_CYCLES clocks while a button stays pressed.
//
// Ports:
//   i_clock   - single clock, rising edge
//   i_reset   - synchronous, active-high reset
//   i_buttons - raw asynchronous button levels (1 = pressed)
//   o_pulse   - registered one-cycle load strobe per channel
//   o_level   - registered debounced level per channel
module btn_debounce_ctrl #(
  parameter int unsigned N_BUTTONS       = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [N_BUTTONS-1:0] i_buttons,
  output logic [N_BUTTONS-1:0] o_pulse,
  output logic [N_BUTTONS-1:0] o_level
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

  // Reject parameter values outside the supported range at elaboration.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24) || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_debounce_ctrl: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
  end

  // Two-flop synchronizer for the raw asynchronous inputs.
  logic [N_BUTTONS-1:0] s1;
  logic [N_BUTTONS-1:0] s2;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= i_buttons;
      s2 <= s1;
    end
  end

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          pulse_q;
    logic          differ_c;
    logic          accept_c;
    logic          repeat_c;

    assign differ_c = s2[g] ^ level_q;
    // The terminal count forces acceptance, so the counter can never wrap.
    assign accept_c = differ_c && (cnt == CNT_LAST);

    // Stability counter and accepted level.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        cnt     <= '0;
        level_q <= 1'b0;
      end else if (!differ_c) begin
        cnt <= '0;
      end else if (accept_c) begin
        cnt     <= '0;
        level_q <= s2[g];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [RW-1:0] rcnt;

    // Repeat timer runs only while the accepted level stays high; the
    // press edge and any level change restart it.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        rcnt <= '0;
      end else if (!level_q || accept_c || rcnt == REP_LAST) begin
        rcnt <= '0;
      end else begin
        rcnt <= rcnt + RW'(1);
      end
    end

    assign repeat_c = level_q && !accept_c && (rcnt == REP_LAST);
`else
    assign repeat_c = 1'b0;
`endif

    // Strobe on an accepted 0->1 change (s2 is 1 there) or a repeat tick.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= (accept_c && s2[g]) || repeat_c;
      end
    end

    assign o_level[g] = level_q;
    assign o_pulse[g] = pulse_q;
  end

endmodule

// File: tb/tb_btn_debounce_ctrl.sv
// Testbench for btn_debounce_ctrl with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Outputs are compared on every clock with a reference model that works
// from the behavioural rules (input seen two clocks late, accepted after
// D consecutive differing clocks, strobe on acceptance of a press, repeat
// every R clocks of held level), plus a fixed vector table and directed
// multi-cycle sequences.
module tb_btn_debounce_ctrl;

  localparam int D = 4;
  localparam int R = 8;
  localparam int N = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] pulse;
  logic [N-1:0] level;

  int n_vec;
  int n_err;

  btn_debounce_ctrl #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_buttons(btn),
    .o_pulse  (pulse),
    .o_level  (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [N-1:0] pipe[$];
  logic [N-1:0] m_pulse;
  logic [N-1:0] m_level;
  int           run[N];
  int           age[N];

  task automatic model_edge();
    logic [N-1:0] used;
    logic [N-1:0] np;
    logic         was;
    logic         changed;
    np = '0;
    if (rst) begin
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_level = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        age[i] = 0;
      end
    end else begin
      // The decision at this edge sees the input applied two edges ago.
      used = pipe.pop_front();
      pipe.push_back(btn);
      for (int i = 0; i < N; i++) begin
        was     = m_level[i];
        changed = 1'b0;
        if (used[i] != was) begin
          run[i]++;
          if (run[i] == D) begin
            run[i]     = 0;
            m_level[i] = used[i];
            changed    = 1'b1;
          end
        end else begin
          run[i] = 0;
        end
        if (changed && m_level[i]) np[i] = 1'b1;
        if (!was || changed) begin
          age[i] = 0;
        end else begin
          age[i]++;
`ifdef BTN_AUTOREPEAT_EN
          if (age[i] % R == 0) np[i] = 1'b1;
`endif
        end
      end
    end
    m_pulse = np;
  endtask

  task automatic check_vec(input string name, input logic [N-1:0] ep, input logic [N-1:0] el);
    n_vec++;
    if (pulse !== ep || level !== el) begin
      n_err++;
      $display("FAIL %s @%0t: pulse=%b level=%b, expected pulse=%b level=%b",
               name, $time, pulse, level, ep, el);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_vec("model", m_pulse, m_level);
  endtask

  // Hold a button pattern for n clocks; count strobes on channel ch.
  task automatic hold(input logic [N-1:0] b, input int n, input int ch,
                      output int cnt, output int first);
    cnt   = 0;
    first = -1;
    btn   = b;
    for (int j = 0; j < n; j++) begin
      step();
      if (pulse[ch]) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
  endtask

  typedef struct packed {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] ep;
    logic [N-1:0] el;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int c;
    int f;
    int c2;
    int f2;
    int all_cnt;
    int any_cnt;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    btn   = '0;

    // Single press on bit 0: entry 1 is edge E0, level rises at E5.
    tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000};
    for (int k = 1; k <= 5; k++) tbl[k] = '{1'b0, 3'b001, 3'b000, 3'b000};
    tbl[6]  = '{1'b0, 3'b001, 3'b001, 3'b001};
    tbl[7]  = '{1'b0, 3'b001, 3'b000, 3'b001};
    tbl[8]  = '{1'b0, 3'b001, 3'b000, 3'b001};
    for (int k = 9; k <= 13; k++) tbl[k] = '{1'b0, 3'b000, 3'b000, 3'b001};
    tbl[14] = '{1'b0, 3'b000, 3'b000, 3'b000};
    tbl[15] = '{1'b0, 3'b000, 3'b000, 3'b000};

    for (int k = 0; k < 16; k++) begin
      rst = tbl[k].rst;
      btn = tbl[k].btn;
      step();
      check_vec("table", tbl[k].ep, tbl[k].el);
    end

    // Glitch: 3 high, 1 low, then held; strobe 5 edges after the final rise.
    hold(3'b010, 3, 1, c, f);
    hold(3'b000, 1, 1, c2, f2);
    check_int("glitch_no_pulse", c + c2, 0);
    hold(3'b010, 12, 1, c, f);
    check_int("glitch_pulse_edge", f, 5);
    check_int("glitch_pulse_count", c, 1);
    hold(3'b000, 8, 1, c, f);
    check_int("glitch_release_level", int'(level), 0);

    // Simultaneous press of all channels, then release.
    all_cnt = 0;
    any_cnt = 0;
    btn = 3'b111;
    for (int j = 0; j < 10; j++) begin
      step();
      if (pulse == 3'b111) all_cnt++;
      if (pulse != 3'b000) any_cnt++;
    end
    check_int("simul_pulse_all", all_cnt, 1);
    check_int("simul_pulse_any", any_cnt, 1);
    any_cnt = 0;
    btn = 3'b000;
    for (int j = 0; j < 10; j++) begin
      step();
      if (pulse != 3'b000) any_cnt++;
    end
    check_int("release_no_pulse", any_cnt, 0);
    check_int("release_level", int'(level), 0);

    // Reset mid-count on bit 2, button held through the release.
    hold(3'b100, 4, 2, c, f);
    check_int("precount_no_pulse", c, 0);
    rst = 1'b1;
    step();
    check_vec("reset_mid_count", 3'b000, 3'b000);
    rst = 1'b0;
    hold(3'b100, 10, 2, c, f);
    check_int("post_reset_pulse_edge", f, 5);
    check_int("post_reset_pulse_count", c, 1);
    hold(3'b000, 8, 2, c, f);

    // Long hold on bit 0: repeats only with the auto-repeat build.
    hold(3'b001, 8, 0, c, f);
    check_int("hold_press_edge", f, 5);
    hold(3'b001, 28, 0, c2, f2);
    c = c + c2 - 1;
`ifdef BTN_AUTOREPEAT_EN
    check_int("hold_repeat_count", c, 3);
`else
    check_int("hold_repeat_count", c, 0);
`endif
    any_cnt = 0;
    btn = 3'b000;
    for (int j = 0; j < 12; j++) begin
      step();
      if (!level[0] && pulse[0]) any_cnt++;
    end
    check_int("hold_release_no_pulse", any_cnt, 0);
    check_int("hold_release_level", int'(level[0]), 0);

    // Random stimulus against the model, with occasional resets.
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) btn[i] = ~btn[i];
      end
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
